fpu_wb_regfile: RTL



---
 rtl/fpu_pkg.sv | 53 +++++
 rtl/fpu_wb_fifo.sv | 62 ++++++
 rtl/fpu_wb_regfile.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types: widths, writeback FIFO entry, and the operation enum used by decode.
// FPU_WB_FFLAGS_EN adds accrued-exception bits to each writeback entry.
package fpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [XLEN-1:0]       data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  is_int;
`ifdef FPU_WB_FFLAGS_EN
    logic [4:0]            fflags;  // NV, DZ, OF, UF, NX
`endif
  } wb_entry_t;

  typedef enum logic [4:0] {
    FPU_OP_FADD,
    FPU_OP_FSUB,
    FPU_OP_FMUL,
    FPU_OP_FDIV,
    FPU_OP_FSQRT,
    FPU_OP_FMIN,
    FPU_OP_FMAX,
    FPU_OP_FMADD,
    FPU_OP_FMSUB,
    FPU_OP_FNMADD,
    FPU_OP_FNMSUB,
    FPU_OP_FSGNJ,
    FPU_OP_FSGNJN,
    FPU_OP_FSGNJX,
    FPU_OP_FEQ,
    FPU_OP_FLT,
    FPU_OP_FLE,
    FPU_OP_FCLASS,
    FPU_OP_FCVT_W_S,
    FPU_OP_FCVT_WU_S,
    FPU_OP_FCVT_S_W,
    FPU_OP_FCVT_S_WU,
    FPU_OP_FMV_X_W,
    FPU_OP_FMV_W_X
  } fpu_op_e;

  // Operations whose result goes to the integer register file rather than f-regs.
  function automatic logic fpu_op_is_int(input fpu_op_e op);
    case (op)
      FPU_OP_FEQ, FPU_OP_FLT, FPU_OP_FLE, FPU_OP_FCLASS,
      FPU_OP_FCVT_W_S, FPU_OP_FCVT_WU_S, FPU_OP_FMV_X_W: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fpu_wb_fifo.sv
// In-order result buffer of wb_entry_t with count/full/empty, plus a per-slot view
// of non-head FP destinations so the top can compute hazard pending flags.
module fpu_wb_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  wb_entry_t                     push_data,
  output wb_entry_t                     head,
  output logic [DEPTH-1:0]              tail_fp,
  output logic [REG_ADDR_W-1:0]         entry_rd [DEPTH],
  output logic [$clog2(DEPTH):0]        count,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] off;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  // Storage is not reset; occupancy is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= push_data;
  end

  always_comb begin
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off         = PTR_W'(i) - rd_ptr;
      entry_rd[i] = mem[i].rd;
      tail_fp[i]  = (off != '0) && ({1'b0, off} < count) && !mem[i].is_int;
    end
  end

endmodule

// File: rtl/fpu_wb_regfile.sv
// FPU writeback: result FIFO draining into the 32-entry FP regfile or the integer port,
// with three bypassed read ports and hazard pending flags. FPU_WB_FFLAGS_EN adds fflags.
module fpu_wb_regfile
  import fpu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [XLEN-1:0]       res_data,
  input  logic [REG_ADDR_W-1:0] res_rd,
  input  logic                  res_is_int,
  output logic                  int_wb_valid,
  input  logic                  int_wb_ready,
  output logic [XLEN-1:0]       int_wb_data,
  output logic [REG_ADDR_W-1:0] int_wb_rd,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [REG_ADDR_W-1:0] rs3_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic [XLEN-1:0]       rs3_data,
  output logic                  rs1_pending,
  output logic                  rs2_pending,
  output logic                  rs3_pending,
  output logic                  fifo_empty
`ifdef FPU_WB_FFLAGS_EN
  ,
  input  logic [4:0]            res_fflags,
  input  logic                  fflags_clr,
  output logic [4:0]            fflags
`endif
);

  wb_entry_t                   push_data;
  wb_entry_t                   head;
  logic [FIFO_DEPTH-1:0]       tail_fp;
  logic [REG_ADDR_W-1:0]       entry_rd [FIFO_DEPTH];
  logic [$clog2(FIFO_DEPTH):0] count;
  logic                        full;
  logic                        empty;
  logic                        pop;
  logic                        fp_head;
  logic [XLEN-1:0]             rf [NREGS];

  always_comb begin
    push_data        = '0;
    push_data.data   = res_data;
    push_data.rd     = res_rd;
    push_data.is_int = res_is_int;
`ifdef FPU_WB_FFLAGS_EN
    push_data.fflags = res_fflags;
`endif
  end

  fpu_wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (res_valid),
    .pop       (pop),
    .push_data (push_data),
    .head      (head),
    .tail_fp   (tail_fp),
    .entry_rd  (entry_rd),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign res_ready    = !full;
  assign fifo_empty   = (count == '0);
  assign fp_head      = !empty && !head.is_int;
  assign int_wb_valid = !empty && head.is_int;
  assign int_wb_data  = int_wb_valid ? head.data : '0;
  assign int_wb_rd    = int_wb_valid ? head.rd : '0;
  // An FP head retires unconditionally; an integer head waits on the integer side.
  assign pop          = fp_head || (int_wb_valid && int_wb_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (fp_head) begin
      rf[head.rd] <= head.data;
    end
  end

  assign rs1_data = (fp_head && head.rd == rs1_addr) ? head.data : rf[rs1_addr];
  assign rs2_data = (fp_head && head.rd == rs2_addr) ? head.data : rf[rs2_addr];
  assign rs3_data = (fp_head && head.rd == rs3_addr) ? head.data : rf[rs3_addr];

  always_comb begin
    rs1_pending = 1'b0;
    rs2_pending = 1'b0;
    rs3_pending = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (tail_fp[i] && entry_rd[i] == rs1_addr) rs1_pending = 1'b1;
      if (tail_fp[i] && entry_rd[i] == rs2_addr) rs2_pending = 1'b1;
      if (tail_fp[i] && entry_rd[i] == rs3_addr) rs3_pending = 1'b1;
    end
  end

`ifdef FPU_WB_FFLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fflags <= '0;
    end else if (fflags_clr) begin
      fflags <= pop ? head.fflags : 5'b0;
    end else if (pop) begin
      fflags <= fflags | head.fflags;
    end
  end
`endif

endmodule
